// File: rtl/vending_machine_gen2.sv
// vending_machine_gen2
//   Parametrised vending controller. It tracks per-product stock and per-denomination
//   coin inventory, credits inserted coins into that inventory and pays change greedily,
//   one coin per cycle.
//
// Build option:
//   VM_CANCEL_EN  when defined, i_cancel in RECEIVE refunds the inserted credit through
//                 the change path (no dispense, no stock decrement). When undefined,
//                 i_cancel is ignored but the port is kept.
//
// Ports:
//   clk                 clock
//   i_rst               synchronous active-high reset
//   i_product_code      selected product
//   i_product_strobe    product select pulse
//   i_currency_code     inserted coin denomination
//   i_currency_strobe   coin inserted pulse
//   i_cancel            cancel request pulse
//   o_busy              transaction in progress
//   o_ready_to_receive  coins accepted this cycle (combinational)
//   o_credit            credit in RECEIVE/EVAL, change owed in CHANGE, else 0
//   o_product           latched product
//   o_change            denomination paid, valid with o_change_strobe
//   o_change_strobe     one coin paid
//   o_no_change         change could not be completed
//   o_give_strobe       dispense product
//   o_sold_out          selection rejected

module vending_machine_gen2 #(
    parameter int unsigned N_PRODUCTS = 4,
    parameter int unsigned N_COINS    = 8,
    parameter int unsigned MONEY_W    = 16,
    parameter logic [N_PRODUCTS*MONEY_W-1:0] PRICES =
        {16'd150, 16'd300, 16'd200, 16'd100},
    parameter logic [N_COINS*MONEY_W-1:0] COIN_VALUES =
        {16'd500, 16'd200, 16'd100, 16'd50, 16'd25, 16'd10, 16'd5, 16'd1},
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned STOCK_INIT = 5,
    parameter int unsigned COIN_INIT  = 10,
    localparam int unsigned PW = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1,
    localparam int unsigned CW = (N_COINS > 1) ? $clog2(N_COINS) : 1
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [PW-1:0]      i_product_code,
    input  logic               i_product_strobe,
    input  logic [CW-1:0]      i_currency_code,
    input  logic               i_currency_strobe,
    input  logic               i_cancel,
    output logic               o_busy,
    output logic               o_ready_to_receive,
    output logic [MONEY_W-1:0] o_credit,
    output logic [PW-1:0]      o_product,
    output logic [CW-1:0]      o_change,
    output logic               o_change_strobe,
    output logic               o_no_change,
    output logic               o_give_strobe,
    output logic               o_sold_out
);

    typedef enum logic [2:0] {
        StIdle,
        StReceive,
        StEval,
        StChange,
        StGive,
        StDone
    } state_e;

    state_e             state_q;
    logic [MONEY_W-1:0] credit_q;
    logic [MONEY_W-1:0] owed_q;
    logic               refund_q;
    logic [PW-1:0]      product_q;
    logic               busy_q;
    logic [CW-1:0]      change_q;
    logic               change_strobe_q;
    logic               no_change_q;
    logic               give_strobe_q;
    logic               sold_out_q;
    logic [CNT_W-1:0]   stock_q    [N_PRODUCTS];
    logic [CNT_W-1:0]   coin_cnt_q [N_COINS];

    // Unpacked views of the packed price / coin tables.
    logic [MONEY_W-1:0] price_val [N_PRODUCTS];
    logic [MONEY_W-1:0] coin_val  [N_COINS];

    for (genvar g = 0; g < N_PRODUCTS; g++) begin : g_price
        assign price_val[g] = PRICES[g*MONEY_W +: MONEY_W];
    end

    for (genvar g = 0; g < N_COINS; g++) begin : g_coin
        assign coin_val[g] = COIN_VALUES[g*MONEY_W +: MONEY_W];
    end

`ifdef VM_CANCEL_EN
`else
    logic unused_cancel;
    assign unused_cancel = i_cancel;
`endif

    logic               prod_valid;
    logic               prod_avail;
    logic               coin_valid;
    logic [MONEY_W:0]   credit_sum;
    logic [MONEY_W-1:0] price_sel;

    assign prod_valid = 32'(i_product_code) < N_PRODUCTS;
    assign prod_avail = prod_valid && (stock_q[i_product_code] != '0);
    assign coin_valid = 32'(i_currency_code) < N_COINS;
    // Extra bit catches credit overflow; such a coin is simply not accepted.
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val[i_currency_code]};
    assign price_sel  = price_val[product_q];

    // Greedy pick: highest denomination that fits the owed amount and is in stock.
    logic               pick_found;
    logic [CW-1:0]      pick_idx;
    logic [MONEY_W-1:0] pick_val;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_val   = '0;
        for (int k = 0; k < N_COINS; k++) begin
            if (coin_val[k] <= owed_q && coin_cnt_q[k] != '0) begin
                pick_found = 1'b1;
                pick_idx   = CW'(k);
                pick_val   = coin_val[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q         <= StIdle;
            credit_q        <= '0;
            owed_q          <= '0;
            refund_q        <= 1'b0;
            product_q       <= '0;
            busy_q          <= 1'b0;
            change_q        <= '0;
            change_strobe_q <= 1'b0;
            no_change_q     <= 1'b0;
            give_strobe_q   <= 1'b0;
            sold_out_q      <= 1'b0;
            for (int i = 0; i < N_PRODUCTS; i++) begin
                stock_q[i] <= CNT_W'(STOCK_INIT);
            end
            for (int i = 0; i < N_COINS; i++) begin
                coin_cnt_q[i] <= CNT_W'(COIN_INIT);
            end
        end else begin
            change_strobe_q <= 1'b0;
            no_change_q     <= 1'b0;
            give_strobe_q   <= 1'b0;
            sold_out_q      <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (i_product_strobe) begin
                        if (prod_avail) begin
                            product_q <= i_product_code;
                            busy_q    <= 1'b1;
                            credit_q  <= '0;
                            state_q   <= StReceive;
                        end else begin
                            sold_out_q <= 1'b1;
                        end
                    end
                end

                StReceive: begin
`ifdef VM_CANCEL_EN
                    // Cancel beats a coin arriving in the same cycle.
                    if (i_cancel) begin
                        owed_q   <= credit_q;
                        refund_q <= 1'b1;
                        state_q  <= StChange;
                    end else
`endif
                    if (i_currency_strobe && coin_valid && !credit_sum[MONEY_W]) begin
                        credit_q <= credit_sum[MONEY_W-1:0];
                        if (coin_cnt_q[i_currency_code] != {CNT_W{1'b1}}) begin
                            coin_cnt_q[i_currency_code] <=
                                coin_cnt_q[i_currency_code] + CNT_W'(1);
                        end
                        state_q <= StEval;
                    end
                end

                StEval: begin
                    if (credit_q < price_sel) begin
                        state_q <= StReceive;
                    end else if (credit_q == price_sel) begin
                        state_q <= StGive;
                    end else begin
                        owed_q  <= credit_q - price_sel;
                        state_q <= StChange;
                    end
                end

                StChange: begin
                    if (owed_q == '0) begin
                        state_q <= refund_q ? StDone : StGive;
                    end else if (pick_found) begin
                        change_q               <= pick_idx;
                        change_strobe_q        <= 1'b1;
                        coin_cnt_q[pick_idx]   <= coin_cnt_q[pick_idx] - CNT_W'(1);
                        owed_q                 <= owed_q - pick_val;
                        if (owed_q == pick_val) begin
                            state_q <= refund_q ? StDone : StGive;
                        end
                    end else begin
                        // Shortfall is forfeited.
                        no_change_q <= 1'b1;
                        owed_q      <= '0;
                        state_q     <= refund_q ? StDone : StGive;
                    end
                end

                StGive: begin
                    give_strobe_q <= 1'b1;
                    if (stock_q[product_q] != '0) begin
                        stock_q[product_q] <= stock_q[product_q] - CNT_W'(1);
                    end
                    state_q <= StDone;
                end

                StDone: begin
                    busy_q   <= 1'b0;
                    credit_q <= '0;
                    owed_q   <= '0;
                    refund_q <= 1'b0;
                    state_q  <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        o_credit = '0;
        case (state_q)
            StReceive, StEval: o_credit = credit_q;
            StChange:          o_credit = owed_q;
            default:           o_credit = '0;
        endcase
    end

    assign o_ready_to_receive = (state_q == StReceive);
    assign o_busy             = busy_q;
    assign o_product          = product_q;
    assign o_change           = change_q;
    assign o_change_strobe    = change_strobe_q;
    assign o_no_change        = no_change_q;
    assign o_give_strobe      = give_strobe_q;
    assign o_sold_out         = sold_out_q;

endmodule

// File: tb/tb_vending_machine_gen2.sv
// Randomised bench for vending_machine_gen2 against a transaction-level model.
// Small stock and coin inventories make sold-out and no-change cases common.
module tb_vending_machine_gen2;

    localparam int unsigned NP    = 3;
    localparam int unsigned NC    = 8;
    localparam int unsigned MW    = 16;
    localparam int unsigned CNTW  = 8;
    localparam int unsigned SINIT = 3;
    localparam int unsigned CINIT = 1;
    localparam logic [NP*MW-1:0] PR = {16'd300, 16'd200, 16'd100};

    int unsigned price_tab [NP] = '{100, 200, 300};
    int unsigned coin_tab  [NC] = '{1, 5, 10, 25, 50, 100, 200, 500};

    logic          clk;
    logic          i_rst;
    logic [1:0]    i_product_code;
    logic          i_product_strobe;
    logic [2:0]    i_currency_code;
    logic          i_currency_strobe;
    logic          i_cancel;
    logic          o_busy;
    logic          o_ready_to_receive;
    logic [MW-1:0] o_credit;
    logic [1:0]    o_product;
    logic [2:0]    o_change;
    logic          o_change_strobe;
    logic          o_no_change;
    logic          o_give_strobe;
    logic          o_sold_out;

    vending_machine_gen2 #(
        .N_PRODUCTS (NP),
        .N_COINS    (NC),
        .MONEY_W    (MW),
        .PRICES     (PR),
        .CNT_W      (CNTW),
        .STOCK_INIT (SINIT),
        .COIN_INIT  (CINIT)
    ) dut (
        .clk                (clk),
        .i_rst              (i_rst),
        .i_product_code     (i_product_code),
        .i_product_strobe   (i_product_strobe),
        .i_currency_code    (i_currency_code),
        .i_currency_strobe  (i_currency_strobe),
        .i_cancel           (i_cancel),
        .o_busy             (o_busy),
        .o_ready_to_receive (o_ready_to_receive),
        .o_credit           (o_credit),
        .o_product          (o_product),
        .o_change           (o_change),
        .o_change_strobe    (o_change_strobe),
        .o_no_change        (o_no_change),
        .o_give_strobe      (o_give_strobe),
        .o_sold_out         (o_sold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model inventories.
    int unsigned m_stock [NP];
    int unsigned m_coins [NC];

    typedef struct {
        bit          cs;
        int unsigned code;
        bit          nc;
        bit          give;
        bit          busy;
        int unsigned credit;
    } exp_t;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
        for (int i = 0; i < NC; i++) m_coins[i] = CINIT;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(o_busy), 0);
        check({tag, "_ready"},  32'(o_ready_to_receive), 0);
        check({tag, "_credit"}, 32'(o_credit), 0);
        check({tag, "_prod"},   32'(o_product), 0);
        check({tag, "_chg"},    32'(o_change), 0);
        check({tag, "_chgs"},   32'(o_change_strobe), 0);
        check({tag, "_noch"},   32'(o_no_change), 0);
        check({tag, "_give"},   32'(o_give_strobe), 0);
        check({tag, "_sold"},   32'(o_sold_out), 0);
    endtask

    // Called right after the edge that enters CHANGE (or GIVE on exact payment).
    task automatic payout(input int unsigned owed_in, input bit refund, input int unsigned code);
        int unsigned owed;
        int          best;
        exp_t        q[$];
        owed = owed_in;
        check("entry_credit", 32'(o_credit), owed);
        check("entry_busy", 32'(o_busy), 1);
        check("entry_ready", 32'(o_ready_to_receive), 0);
        if (refund && owed == 0) q.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b1, 0});
        while (owed > 0) begin
            best = -1;
            for (int k = 0; k < NC; k++) begin
                if (coin_tab[k] <= owed && m_coins[k] > 0) best = k;
            end
            if (best < 0) break;
            m_coins[best]--;
            owed -= coin_tab[best];
            q.push_back('{1'b1, best, 1'b0, 1'b0, 1'b1, owed});
        end
        if (owed > 0) q.push_back('{1'b0, 0, 1'b1, 1'b0, 1'b1, 0});
        if (!refund) begin
            q.push_back('{1'b0, 0, 1'b0, 1'b1, 1'b1, 0});
            m_stock[code]--;
        end
        q.push_back('{1'b0, 0, 1'b0, 1'b0, 1'b0, 0});
        foreach (q[i]) begin
            step();
            check("pay_chgs", 32'(o_change_strobe), 32'(q[i].cs));
            if (q[i].cs) check("pay_code", 32'(o_change), q[i].code);
            check("pay_noch", 32'(o_no_change), 32'(q[i].nc));
            check("pay_give", 32'(o_give_strobe), 32'(q[i].give));
            check("pay_busy", 32'(o_busy), 32'(q[i].busy));
            check("pay_credit", 32'(o_credit), q[i].credit);
            check("pay_ready", 32'(o_ready_to_receive), 0);
        end
        check("end_product", 32'(o_product), code);
    endtask

    task automatic txn();
        int unsigned code, credit, price, ncoins, cc;
        bit          ok, c, s, done;
        if ($urandom_range(0, 3) == 0) begin
            i_currency_code   = 3'($urandom_range(0, 7));
            i_currency_strobe = 1'b1;
            step();
            i_currency_strobe = 1'b0;
            check("idle_coin_credit", 32'(o_credit), 0);
            check("idle_coin_ready", 32'(o_ready_to_receive), 0);
        end
        code             = $urandom_range(0, 3);
        i_product_code   = 2'(code);
        i_product_strobe = 1'b1;
        step();
        i_product_strobe = 1'b0;
        ok = (code < NP) && (m_stock[code] > 0);
        check("sold_out", 32'(o_sold_out), 32'(!ok));
        check("sel_busy", 32'(o_busy), 32'(ok));
        check("sel_ready", 32'(o_ready_to_receive), 32'(ok));
        if (ok) begin
            check("sel_product", 32'(o_product), code);
            price  = price_tab[code];
            credit = 0;
            ncoins = 0;
            done   = 1'b0;
            for (int it = 0; it < 40 && !done; it++) begin
                c  = ($urandom_range(0, 5) == 0);
                s  = c ? 1'($urandom_range(0, 1)) : 1'b1;
                cc = (ncoins >= 5) ? 7 : $urandom_range(0, 7);
                i_cancel          = c;
                i_currency_strobe = s;
                i_currency_code   = 3'(cc);
                step();
                i_cancel          = 1'b0;
                i_currency_strobe = 1'b0;
`ifdef VM_CANCEL_EN
                if (c) begin
                    payout(credit, 1'b1, code);
                    done = 1'b1;
                end else
`endif
                if (!s) begin
                    check("hold_ready", 32'(o_ready_to_receive), 1);
                    check("hold_credit", 32'(o_credit), credit);
                end else begin
                    ncoins++;
                    credit += coin_tab[cc];
                    if (m_coins[cc] < 255) m_coins[cc]++;
                    check("eval_credit", 32'(o_credit), credit);
                    check("eval_ready", 32'(o_ready_to_receive), 0);
                    step();
                    if (credit < price) begin
                        check("recv_ready", 32'(o_ready_to_receive), 1);
                        check("recv_credit", 32'(o_credit), credit);
                    end else begin
                        payout(credit - price, 1'b0, code);
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                check("txn_bound", 0, 1);
                i_rst = 1'b1;
                step();
                i_rst = 1'b0;
                model_reset();
            end
        end
    endtask

    initial begin
        i_rst             = 1'b1;
        i_product_code    = '0;
        i_product_strobe  = 1'b0;
        i_currency_code   = '0;
        i_currency_strobe = 1'b0;
        i_cancel          = 1'b0;
        step();
        step();
        check_all_zero("reset");
        i_rst = 1'b0;
        model_reset();

        repeat (80) txn();

        // Reset in the middle of paying change: product 0 (100) with a 500 coin.
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        model_reset();
        i_product_code   = 2'd0;
        i_product_strobe = 1'b1;
        step();
        i_product_strobe  = 1'b0;
        i_currency_code   = 3'd7;
        i_currency_strobe = 1'b1;
        step();
        i_currency_strobe = 1'b0;
        check("mid_eval_credit", 32'(o_credit), 500);
        step();
        check("mid_change_owed", 32'(o_credit), 400);
        step();
        check("mid_first_strobe", 32'(o_change_strobe), 1);
        check("mid_first_code", 32'(o_change), 6);
        i_rst            = 1'b1;
        i_product_strobe = 1'b1;
        step();
        i_rst            = 1'b0;
        i_product_strobe = 1'b0;
        check_all_zero("midrst");
        model_reset();

        repeat (60) txn();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
